imem_prefetch: RTL and testbench

Instruction prefetch queue between the core's fetch stage and the read port of the instruction memory model (`mem2ports`). It streams sequential word-aligned read requests into the memory, captures the one-cycle-latency responses into a small FIFO, and presents instructions to the core through a valid/ready handshake. A flush from the core redirects fetch and discards all queued and in-flight data.

---
 rtl/prefetch_pkg.sv | 10 +
 rtl/sync_fifo.sv | 36 +++
 rtl/imem_prefetch.sv | 73 +++++++
 tb/tb_imem_prefetch.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared types and widths for the instruction prefetch queue
package prefetch_pkg;
  localparam int PC_W = 30;
  localparam int INST_W = 32;
  typedef enum logic {RESET, RUN} state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock fifo with clear, occupancy count and head output
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic resetb,
  input  logic push,
  input  logic pop,
  input  logic clr,
  input  logic [W-1:0] din,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign dout = mem[rptr];
  always_ff @(posedge clk or posedge resetb)
    if (resetb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wptr] <= din;
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/imem_prefetch.sv
// imem_prefetch: sequential instruction prefetch queue with flush and credit-based issue
module imem_prefetch
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic resetb,
  output logic rready,
  output logic [31:1] raddr,
  input  logic rresp,
  input  logic [31:0] rdata,
  input  logic flush,
  input  logic [31:2] flush_pc,
  output logic inst_valid,
  input  logic inst_ready,
  output logic [31:0] inst_data,
  output logic [31:2] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state_q, state_d;
  logic [PC_W-1:0] fetch_pc, resp_pc;
  logic inflight, discard, run, issue, push, pop, clr;
  logic [CW-1:0] count;
  logic [CW:0] used;
  fifo_entry_t head, din;
  assign used = {1'b0, count} + (CW+1)'(inflight);
  assign din = {resp_pc, rdata};
  assign raddr = {fetch_pc, 1'b0};
  assign rready = issue;
  assign inst_valid = count != '0;
  assign inst_pc = head.pc;
  assign inst_data = head.data;
  always_comb begin
    state_d = RUN;
    run = state_q == RUN;
    clr = run & flush;
    issue = run & !flush & (used < (CW+1)'(DEPTH));
    push = run & !flush & rresp & inflight & !discard;
    pop = run & !flush & inst_valid & inst_ready;
  end
  always_ff @(posedge clk or posedge resetb)
    if (resetb) begin
      state_q <= RESET;
      fetch_pc <= RESET_PC[31:2];
      resp_pc <= RESET_PC[31:2];
      inflight <= 1'b0;
      discard <= 1'b0;
    end else begin
      state_q <= state_d;
      inflight <= issue;
      if (issue) resp_pc <= fetch_pc;
      fetch_pc <= clr ? flush_pc : issue ? fetch_pc + 1'b1 : fetch_pc;
      discard <= clr ? inflight & !rresp : rresp ? 1'b0 : discard;
    end
  sync_fifo #(
    .W($bits(fifo_entry_t)),
    .DEPTH(DEPTH),
    .RST_VAL({RESET_PC[31:2], {INST_W{1'b0}}})
  ) u_fifo (
    .clk(clk),
    .resetb(resetb),
    .push(push),
    .pop(pop),
    .clr(clr),
    .din(din),
    .count(count),
    .dout(head)
  );
  assert property (@(posedge clk) disable iff (resetb) (rresp && state_q == RUN) |-> inflight)
    else $error("imem_prefetch: response without an outstanding request");
endmodule

// File: tb/tb_imem_prefetch.sv
// tb_imem_prefetch: directed vector bench for the instruction prefetch queue
module tb_imem_prefetch;
  logic clk = 1'b0;
  logic resetb = 1'b1;
  logic rready, rresp = 1'b0, flush = 1'b0, inst_valid, inst_ready = 1'b0;
  logic [31:1] raddr;
  logic [31:0] rdata = '0, inst_data;
  logic [31:2] flush_pc = '0, inst_pc;
  int n_chk = 0, n_fail = 0, n_iss;
  typedef struct {
    logic f;
    logic [29:0] fp;
    logic ir;
    logic er;
    logic [29:0] ea;
    logic ev;
    logic [29:0] ep;
  } vec_t;
  vec_t v[24];
  always #5 clk = ~clk;
  imem_prefetch #(.DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk),
    .resetb(resetb),
    .rready(rready),
    .raddr(raddr),
    .rresp(rresp),
    .rdata(rdata),
    .flush(flush),
    .flush_pc(flush_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
  );
  always @(posedge clk) begin
    rresp <= rready;
    rdata <= 32'hA000_0000 + {2'b00, raddr[31:2]};
  end
  function automatic logic [31:0] md(input logic [29:0] pc);
    return 32'hA000_0000 + {2'b00, pc};
  endfunction
  function automatic vec_t mk(input logic f, input logic [29:0] fp, input logic ir,
                              input logic er, input logic [29:0] ea, input logic ev, input logic [29:0] ep);
    mk = '{f, fp, ir, er, ea, ev, ep};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic f, input logic [29:0] fp, input logic ir);
    @(posedge clk);
    #1;
    flush = f;
    flush_pc = fp;
    inst_ready = ir;
    @(negedge clk);
  endtask
  task automatic outs(input string tag, input logic er, input logic [29:0] ea, input logic ev, input logic [29:0] ep);
    chk({tag, ".rready"}, 64'(rready), 64'(er));
    chk({tag, ".raddr"}, 64'(raddr), 64'({ea, 1'b0}));
    chk({tag, ".valid"}, 64'(inst_valid), 64'(ev));
    if (ev) begin
      chk({tag, ".pc"}, 64'(inst_pc), 64'(ep));
      chk({tag, ".data"}, 64'(inst_data), 64'(md(ep)));
    end
  endtask
  task automatic reset_vals(input string tag);
    outs(tag, 1'b0, 30'h40, 1'b0, 30'h0);
    chk({tag, ".data"}, 64'(inst_data), 64'h0);
    chk({tag, ".pc"}, 64'(inst_pc), 64'h40);
  endtask
  initial begin
    v[0]  = mk(0, 0, 1, 1, 30'h40, 0, 0);
    v[1]  = mk(0, 0, 1, 1, 30'h41, 0, 0);
    v[2]  = mk(0, 0, 1, 1, 30'h42, 1, 30'h40);
    v[3]  = mk(0, 0, 1, 1, 30'h43, 1, 30'h41);
    v[4]  = mk(0, 0, 1, 1, 30'h44, 1, 30'h42);
    v[5]  = mk(1, 30'h200, 1, 0, 30'h45, 1, 30'h43);
    v[6]  = mk(0, 0, 1, 1, 30'h200, 0, 0);
    v[7]  = mk(0, 0, 1, 1, 30'h201, 0, 0);
    v[8]  = mk(0, 0, 1, 1, 30'h202, 1, 30'h200);
    v[9]  = mk(0, 0, 1, 1, 30'h203, 1, 30'h201);
    v[10] = mk(1, 30'h300, 1, 0, 30'h204, 1, 30'h202);
    v[11] = mk(1, 30'h3FFF_FFFF, 1, 0, 30'h300, 0, 0);
    v[12] = mk(0, 0, 1, 1, 30'h3FFF_FFFF, 0, 0);
    v[13] = mk(0, 0, 1, 1, 30'h0, 0, 0);
    for (int c = 15; c <= 24; c++) v[c-1] = mk(0, 0, 1, 1, 30'(c - 14), 1, 30'(c - 16));
    #12;
    reset_vals("reset");
    @(negedge clk);
    resetb = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(v[i].f, v[i].fp, v[i].ir);
      outs($sformatf("vec%0d", i + 1), v[i].er, v[i].ea, v[i].ev, v[i].ep);
    end
    step(1'b1, 30'h500, 1'b0);
    chk("bp_flush.rready", 64'(rready), 64'h0);
    n_iss = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 30'h0, 1'b0);
      n_iss += int'(rready);
      if (k == 6) outs("bp_full", 1'b0, 30'h504, 1'b1, 30'h500);
    end
    chk("bp_issues", 64'(n_iss), 64'd4);
    step(1'b0, 30'h0, 1'b1);
    outs("bp_pop", 1'b0, 30'h504, 1'b1, 30'h500);
    step(1'b0, 30'h0, 1'b0);
    outs("bp_refill", 1'b1, 30'h504, 1'b1, 30'h501);
    n_iss = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 30'h0, 1'b0);
      n_iss += int'(rready);
    end
    chk("bp_one_issue", 64'(n_iss), 64'd0);
    step(1'b1, 30'h600, 1'b1);
    outs("ff_flush", 1'b0, 30'h505, 1'b1, 30'h501);
    step(1'b0, 30'h0, 1'b1);
    outs("ff_f1", 1'b1, 30'h600, 1'b0, 0);
    step(1'b0, 30'h0, 1'b1);
    outs("ff_f2", 1'b1, 30'h601, 1'b0, 0);
    step(1'b0, 30'h0, 1'b1);
    outs("ff_f3", 1'b1, 30'h602, 1'b1, 30'h600);
    step(1'b0, 30'h0, 1'b1);
    outs("ff_f4", 1'b1, 30'h603, 1'b1, 30'h601);
    @(posedge clk);
    #2;
    resetb = 1'b1;
    #1;
    reset_vals("midreset");
    @(negedge clk);
    resetb = 1'b0;
    step(1'b0, 30'h0, 1'b1);
    outs("rst_c1", 1'b1, 30'h40, 1'b0, 0);
    step(1'b0, 30'h0, 1'b1);
    outs("rst_c2", 1'b1, 30'h41, 1'b0, 0);
    step(1'b0, 30'h0, 1'b1);
    outs("rst_c3", 1'b1, 30'h42, 1'b1, 30'h40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
